// File: rtl/i2s_pkg.sv
// Shared constants and sample types for the I2S transmitter and its clock generator.
// Samples are stored at the widest legal width; narrower WIDTH values are zero-extended.
package i2s_pkg;
  localparam int CNT_W     = 9;
  localparam int SLOT_BITS = 32;
  localparam int SCKI_BIT  = 0;
  localparam int BCK_BIT   = 2;
  localparam int LRCK_BIT  = 8;
  localparam int MAX_WIDTH = SLOT_BITS - 1;

  typedef logic [MAX_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } pair_t;
endpackage

// File: rtl/i2s_clkgen.sv
// Free-running 9-bit frame counter producing SCKI/BCK/LRCK and bit/frame strobes.
// Reusable as the master-mode clock source for the receiver.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       scki,
  output logic       bck,
  output logic       lrck,
  output logic [5:0] bit_pos,
  output logic       bit_edge,
  output logic       frame_wrap
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + CNT_W'(1);
  end

  // Clocks come straight from register bits so they are glitch-free.
  assign scki       = cnt[SCKI_BIT];
  assign bck        = cnt[BCK_BIT];
  assign lrck       = cnt[LRCK_BIT];
  assign bit_pos    = cnt[CNT_W-1:BCK_BIT+1];
  assign bit_edge   = &cnt[BCK_BIT:0];
  assign frame_wrap = &cnt;
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-pair holding buffer, per-frame word latch, MSB-first serialiser.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of sending silence.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             bck,
  output logic             lrck,
  output logic             scki,
  output logic             underrun
);
  // Handshake: a pair transfers on a clk edge where in_valid & in_ready; in_ready
  // is high exactly while the holding buffer is empty and does not depend on in_valid.
  logic [5:0] bit_pos;
  logic       bit_edge;
  logic       frame_wrap;
  logic       buf_full;
  logic       xfer;
  pair_t      hold_buf;
  pair_t      frame;
  logic [4:0] slot;
  logic       ch;
  logic [4:0] bit_idx;
  logic       slot_bit;

  i2s_clkgen u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .scki       (scki),
    .bck        (bck),
    .lrck       (lrck),
    .bit_pos    (bit_pos),
    .bit_edge   (bit_edge),
    .frame_wrap (frame_wrap)
  );

  assign in_ready = ~buf_full;
  assign xfer     = in_valid & ~buf_full;

  // dout changes as the counter enters a new slot, so look one slot ahead.
  assign {ch, slot} = bit_pos + 6'd1;

  always_comb begin
    bit_idx  = '0;
    slot_bit = 1'b0;
    if (slot != 5'd0 && int'(slot) <= WIDTH) begin
      bit_idx  = 5'(WIDTH - int'(slot));
      slot_bit = ch ? frame.right[bit_idx] : frame.left[bit_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      hold_buf <= '0;
      frame    <= '0;
      underrun <= 1'b0;
      dout     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (bit_edge) dout <= slot_bit;
      if (frame_wrap) begin
        if (buf_full) begin
          frame    <= hold_buf;
          buf_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
          frame    <= frame;
`else
          frame    <= '0;
`endif
        end
      end
      // A transfer can only coincide with the wrap when the buffer was empty.
      if (xfer) begin
        hold_buf.left  <= sample_t'(left);
        hold_buf.right <= sample_t'(right);
        buf_full       <= 1'b1;
      end
    end
  end
endmodule
